// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-to-binary converter: default width and
// the bit-level helper functions used by the converter and its step checker.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  // MSB-first XOR chain on a zero-extended word. Zeros above the real width
  // contribute nothing to the chain, so the low WIDTH bits of the result are
  // the binary value of a WIDTH-bit Gray word.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits; used as the Hamming distance between two samples.
  function automatic logic [5:0] popcount(input logic [GRAY_W_MAX-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_binary_converter_sf_if.sv
// Bus between a Gray-coded source and the converter: the sampled input word
// with its valid, and the combinational and registered results.
interface gray_binary_converter_sf_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] b_comb;
  logic             out_valid;
  logic [WIDTH-1:0] b;
  logic             step_err;

  // Source side: drives Gray words, observes results.
  modport master (
    output in_valid, g,
    input  b_comb, out_valid, b, step_err
  );

  // Converter side.
  modport slave (
    input  in_valid, g,
    output b_comb, out_valid, b, step_err
  );

endinterface

// File: rtl/gray2bin_chain.sv
// Purely combinational Gray-to-binary conversion of a WIDTH-bit word.
module gray2bin_chain
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // Each binary bit is the running XOR of all Gray bits from the MSB down.
  always_comb begin
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
  end

endmodule

// File: rtl/gray_binary_converter_sf.sv
// Gray-to-binary converter with a combinational result, a 1-cycle registered
// valid-qualified result, and a flag for inputs that break the Gray
// single-bit-step property relative to the previous accepted word.
module gray_binary_converter_sf
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  gray_binary_converter_sf_if.slave   bus
);

  logic [WIDTH-1:0] b_comb_w;

  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic             step_err_q, step_err_d;
  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic             have_prev_q, have_prev_d;

  logic [5:0]       step_dist;

  gray2bin_chain #(.WIDTH(WIDTH)) u_chain (
    .g (bus.g),
    .b (b_comb_w)
  );

  // Hamming distance between the incoming word and the last accepted one.
  assign step_dist = popcount(GRAY_W_MAX'(bus.g ^ prev_g_q));

  // Next-state: accept g on in_valid, otherwise hold result and history.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    b_d         = b_q;
    prev_g_d    = prev_g_q;
    have_prev_d = have_prev_q;
    out_valid_d = bus.in_valid;
    step_err_d  = 1'b0;
    if (bus.in_valid) begin
      b_d         = b_comb_w;
      prev_g_d    = bus.g;
      have_prev_d = 1'b1;
      // The first word after reset has nothing to compare against.
      step_err_d  = have_prev_q && (step_dist != 6'd1);
    end
  end

  // State registers; reset clears the history so the next word is "first".
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      b_q         <= '0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      prev_g_q    <= '0;
      have_prev_q <= 1'b0;
    end else begin
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      step_err_q  <= step_err_d;
      prev_g_q    <= prev_g_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign bus.b_comb    = b_comb_w;
  assign bus.b         = b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.step_err  = step_err_q;

endmodule

// File: tb/tb_gray_binary_converter_sf.sv
// Self-checking bench for gray_binary_converter_sf at WIDTH=4 and WIDTH=8.
// The reference model inverts the Gray code by table lookup (Gray of n is
// n ^ (n >> 1)) and tracks the step property with $countones.
module tb_gray_binary_converter_sf;

  logic clk;
  logic rst;

  int checks;
  int errors;

  gray_binary_converter_sf_if #(.WIDTH(4)) bus4 ();
  gray_binary_converter_sf_if #(.WIDTH(8)) bus8 ();

  gray_binary_converter_sf #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  gray_binary_converter_sf #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables: Gray word -> binary value.
  logic [3:0] inv4 [16];
  logic [7:0] inv8 [256];

  // Model state and expected outputs.
  logic       m_have4, m_have8;
  logic [3:0] m_prev4;
  logic [7:0] m_prev8;
  logic [3:0] exp_b4;
  logic [7:0] exp_b8;
  logic       exp_ov4, exp_se4, exp_ov8, exp_se8;

  task automatic model_reset();
    m_have4 = 1'b0; m_prev4 = '0; exp_b4 = '0; exp_ov4 = 1'b0; exp_se4 = 1'b0;
    m_have8 = 1'b0; m_prev8 = '0; exp_b8 = '0; exp_ov8 = 1'b0; exp_se8 = 1'b0;
  endtask

  // Drive one cycle on the 4-bit DUT and advance the model; returns #1 after the edge.
  task automatic apply4(input logic v, input logic [3:0] gi);
    @(negedge clk);
    bus4.in_valid = v;
    bus4.g        = gi;
    exp_ov4 = v;
    if (v) begin
      exp_se4 = m_have4 && ($countones(gi ^ m_prev4) != 1);
      exp_b4  = inv4[gi];
      m_prev4 = gi;
      m_have4 = 1'b1;
    end else begin
      exp_se4 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply8(input logic v, input logic [7:0] gi);
    @(negedge clk);
    bus8.in_valid = v;
    bus8.g        = gi;
    exp_ov8 = v;
    if (v) begin
      exp_se8 = m_have8 && ($countones(gi ^ m_prev8) != 1);
      exp_b8  = inv8[gi];
      m_prev8 = gi;
      m_have8 = 1'b1;
    end else begin
      exp_se8 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.g = '0;
    bus8.in_valid = 1'b0; bus8.g = '0;
    model_reset();
    #12;
    checks++;
    if (bus4.b !== 4'b0000 || bus4.out_valid !== 1'b0 || bus4.step_err !== 1'b0) begin
      errors++;
      $display("FAIL reset4: got b=%b ov=%b se=%b, expected b=0000 ov=0 se=0",
               bus4.b, bus4.out_valid, bus4.step_err);
    end
    checks++;
    if (bus8.b !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.step_err !== 1'b0) begin
      errors++;
      $display("FAIL reset8: got b=%h ov=%b se=%b, expected b=00 ov=0 se=0",
               bus8.b, bus8.out_valid, bus8.step_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep();
    logic [3:0] sg [8];
    logic [3:0] sb [8];
    sg = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b1010, 4'b1111};
    sb = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b1111, 4'b1100, 4'b1010};
    for (int i = 0; i < 16; i++) begin
      apply4(1'b0, 4'(i));
      checks++;
      if (bus4.b_comb !== inv4[i]) begin
        errors++;
        $display("FAIL comb_sweep g=%b: got %b expected %b", 4'(i), bus4.b_comb, inv4[i]);
      end
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.step_err !== 1'b0) begin
        errors++;
        $display("FAIL comb_idle g=%b: got ov=%b se=%b expected 0 0",
                 4'(i), bus4.out_valid, bus4.step_err);
      end
    end
    for (int i = 0; i < 8; i++) begin
      apply4(1'b0, sg[i]);
      checks++;
      if (bus4.b_comb !== sb[i]) begin
        errors++;
        $display("FAIL comb_const g=%b: got %b expected %b", sg[i], bus4.b_comb, sb[i]);
      end
    end
  endtask

  task automatic test_registered();
    apply4(1'b1, 4'b0110);
    checks++;
    if (bus4.b !== 4'b0100 || bus4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reg_accept: got b=%b ov=%b expected b=0100 ov=1", bus4.b, bus4.out_valid);
    end
    apply4(1'b0, 4'b1111);
    checks++;
    if (bus4.b !== 4'b0100 || bus4.out_valid !== 1'b0 || bus4.step_err !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold: got b=%b ov=%b se=%b expected b=0100 ov=0 se=0",
               bus4.b, bus4.out_valid, bus4.step_err);
    end
  endtask

  task automatic test_gray_stream();
    logic [3:0] seq [5];
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      apply4(1'b1, seq[i]);
      checks++;
      if (bus4.step_err !== 1'b0 || bus4.b !== inv4[seq[i]] || bus4.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL gray_stream[%0d]: got se=%b b=%b ov=%b expected se=0 b=%b ov=1",
                 i, bus4.step_err, bus4.b, bus4.out_valid, inv4[seq[i]]);
      end
    end
    apply4(1'b1, 4'b0110);
    checks++;
    if (bus4.step_err !== 1'b1) begin
      errors++;
      $display("FAIL repeat_word: got se=%b expected 1", bus4.step_err);
    end
    apply4(1'b0, 4'b0110);
    checks++;
    if (bus4.step_err !== 1'b0 || bus4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: got se=%b ov=%b expected 0 0", bus4.step_err, bus4.out_valid);
    end
  endtask

  task automatic test_binary_stream();
    logic [3:0] seq [3];
    logic       se  [3];
    seq = '{4'b0000, 4'b0001, 4'b0010};
    se  = '{1'b0, 1'b0, 1'b1};
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      apply4(1'b1, seq[i]);
      checks++;
      if (bus4.step_err !== se[i]) begin
        errors++;
        $display("FAIL binary_stream[%0d]: got se=%b expected %b", i, bus4.step_err, se[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    apply4(1'b1, 4'b0101);
    apply4(1'b1, 4'b0111);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus4.b !== 4'b0000 || bus4.out_valid !== 1'b0 || bus4.step_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got b=%b ov=%b se=%b expected b=0000 ov=0 se=0",
               bus4.b, bus4.out_valid, bus4.step_err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply4(1'b1, 4'b1111);
    checks++;
    if (bus4.b !== 4'b1010 || bus4.step_err !== 1'b0 || bus4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got b=%b se=%b ov=%b expected b=1010 se=0 ov=1",
               bus4.b, bus4.step_err, bus4.out_valid);
    end
  endtask

  // Full Gray cycle fed every cycle, including the 1000 -> 0000 wrap.
  task automatic test_back_to_back();
    pulse_reset();
    for (int n = 0; n <= 16; n++) begin
      logic [3:0] nv;
      nv = 4'(n);
      apply4(1'b1, nv ^ (nv >> 1));
      checks++;
      if (bus4.b !== nv || bus4.step_err !== 1'b0 || bus4.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back n=%0d: got b=%b se=%b ov=%b expected b=%b se=0 ov=1",
                 n, bus4.b, bus4.step_err, bus4.out_valid, nv);
      end
    end
  endtask

  task automatic test_random4();
    for (int i = 0; i < 300; i++) begin
      logic       v;
      logic [3:0] gi;
      int         mode;
      v    = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 3);
      if (mode == 0)      gi = 4'($urandom);
      else if (mode == 1) gi = m_prev4;
      else                gi = m_prev4 ^ (4'b0001 << $urandom_range(0, 3));
      apply4(v, gi);
      checks++;
      if (bus4.b_comb !== inv4[gi] || bus4.b !== exp_b4 ||
          bus4.out_valid !== exp_ov4 || bus4.step_err !== exp_se4) begin
        errors++;
        $display("FAIL random4[%0d] g=%b v=%b: got bc=%b b=%b ov=%b se=%b expected bc=%b b=%b ov=%b se=%b",
                 i, gi, v, bus4.b_comb, bus4.b, bus4.out_valid, bus4.step_err,
                 inv4[gi], exp_b4, exp_ov4, exp_se4);
      end
    end
  endtask

  task automatic test_width8();
    pulse_reset();
    apply8(1'b1, 8'b1000_0000);
    checks++;
    if (bus8.b !== 8'b1111_1111 || bus8.b_comb !== 8'b1111_1111 || bus8.step_err !== 1'b0) begin
      errors++;
      $display("FAIL w8_msb: got b=%b bc=%b se=%b expected b=11111111 bc=11111111 se=0",
               bus8.b, bus8.b_comb, bus8.step_err);
    end
    apply8(1'b1, 8'b1111_1111);
    checks++;
    if (bus8.b !== 8'b1010_1010 || bus8.b_comb !== 8'b1010_1010) begin
      errors++;
      $display("FAIL w8_ones: got b=%b bc=%b expected 10101010", bus8.b, bus8.b_comb);
    end
    for (int i = 0; i < 200; i++) begin
      logic       v;
      logic [7:0] gi;
      v  = ($urandom_range(0, 3) != 0);
      gi = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                       : m_prev8 ^ (8'b0000_0001 << $urandom_range(0, 7));
      apply8(v, gi);
      checks++;
      if (bus8.b_comb !== inv8[gi] || bus8.b !== exp_b8 ||
          bus8.out_valid !== exp_ov8 || bus8.step_err !== exp_se8) begin
        errors++;
        $display("FAIL random8[%0d] g=%h v=%b: got bc=%h b=%h ov=%b se=%b expected bc=%h b=%h ov=%b se=%b",
                 i, gi, v, bus8.b_comb, bus8.b, bus8.out_valid, bus8.step_err,
                 inv8[gi], exp_b8, exp_ov8, exp_se8);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nv;
      nv = 4'(n);
      inv4[nv ^ (nv >> 1)] = nv;
    end
    for (int n = 0; n < 256; n++) begin
      logic [7:0] nv;
      nv = 8'(n);
      inv8[nv ^ (nv >> 1)] = nv;
    end
    test_reset();
    test_comb_sweep();
    test_registered();
    test_gray_stream();
    test_binary_stream();
    test_reset_mid_stream();
    test_back_to_back();
    test_random4();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
